// File: rtl/seg7_pkg.sv
// Shared encodings and widths for the seven-segment display arbiter.
package seg7_pkg;
  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_OWN  = 1'b1;
  localparam int   DISP_W  = 8;
  localparam int   IDX_W   = 3;
endpackage

// File: rtl/rr_pick.sv
// Rotate-priority picker: first set req bit searching upward from ptr+1 with wrap.
module rr_pick
  import seg7_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  // Scan from the far end so the nearest candidate after ptr overwrites last;
  // ptr itself has lowest priority, which lets a lone owner keep the grant.
  always_comb begin
    valid = |req;
    idx   = '0;
    for (int k = NREQ; k >= 1; k--) begin
      automatic int c = (int'(ptr) + k) % NREQ;
      if (req[c]) idx = IDX_W'(c);
    end
  end

endmodule

// File: rtl/seg7_disp_arbiter.sv
// Round-robin owner of the two-digit hex display with a minimum dwell per owner.
module seg7_disp_arbiter
  import seg7_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int DWELL = 1000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*DISP_W-1:0] data,
  output logic [NREQ-1:0]        grant,
  output logic [DISP_W-1:0]      disp_bin,
  output logic                   disp_blank,
  output logic [IDX_W-1:0]       disp_src,
  output logic                   busy
);

  localparam int               CNT_W  = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DWELL - 1);

  logic              state, state_nx;
  logic [IDX_W-1:0]  ptr;
  logic [CNT_W-1:0]  cnt;
  logic              pick_vld;
  logic [IDX_W-1:0]  pick_idx;
  logic              owner_req;
  logic [DISP_W-1:0] own_byte, pick_byte;
  logic [NREQ-1:0]   grant_nx;
  logic              do_grant, do_idle;

  // ptr always equals the current owner while in OWN, so one picker covers
  // initial grant, owner drop and dwell expiry.
  rr_pick #(.NREQ(NREQ)) u_pick (
    .req   (req),
    .ptr   (ptr),
    .valid (pick_vld),
    .idx   (pick_idx)
  );

  always_comb begin
    owner_req = 1'b0;
    own_byte  = '0;
    pick_byte = '0;
    grant_nx  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IDX_W'(i) == disp_src) begin
        owner_req = req[i];
        own_byte  = data[i*DISP_W +: DISP_W];
      end
      if (IDX_W'(i) == pick_idx) begin
        pick_byte   = data[i*DISP_W +: DISP_W];
        grant_nx[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (pick_vld) state_nx = ST_OWN;
      ST_OWN:  if (!owner_req && !pick_vld) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    do_grant = pick_vld && ((state == ST_IDLE) || !owner_req || (cnt == '0));
    do_idle  = (state == ST_OWN) && !owner_req && !pick_vld;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      ptr      <= IDX_W'(NREQ - 1);
      cnt      <= '0;
      grant    <= '0;
      disp_src <= '0;
      disp_bin <= '0;
    end else begin
      state <= state_nx;
      if (do_grant) begin
        grant    <= grant_nx;
        disp_src <= pick_idx;
        ptr      <= pick_idx;
        cnt      <= RELOAD;
        disp_bin <= pick_byte;
      end else if (do_idle) begin
        grant    <= '0;
        disp_src <= '0;
        cnt      <= '0;
      end else if (state == ST_OWN) begin
        disp_bin <= own_byte;
        if (cnt != '0) cnt <= cnt - 1'b1;
      end
    end
  end

  assign busy       = |grant;
  assign disp_blank = ~busy;

endmodule
